// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: decode-stage RAW hazard detector for a 5-stage pipeline
// without forwarding. A 2-entry scoreboard (EX slot, MEM slot) holds the
// destination registers of in-flight writers. When the ID instruction reads
// one of them, ST is raised and the PC and IF/ID register are held.
// Optional build macro: HAZARD_STALL_CNT_EN enables the saturating stall
// counter; without it stall_cnt is tied to zero.
module hazard_stall_unit #(
    parameter int INSTR_W    = 16,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               ST,
    output logic               pc_write_en,
    output logic               ifid_write_en,
    output logic               sb_ex_valid,
    output logic               sb_mem_valid,
    output logic [CNT_W-1:0]   stall_cnt
);

    // Opcode encodings understood by this pipeline
    localparam logic [3:0] OP_SW   = 4'b0000;
    localparam logic [3:0] OP_NOR  = 4'b0001;
    localparam logic [3:0] OP_ADDI = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1111;

    // Field positions: opcode [15:12], rd [11:8], rs [7:4], rt/imm [3:0]
    localparam int OP_LSB = INSTR_W - 4;
    localparam int RD_LSB = OP_LSB - REG_ADDR_W;
    localparam int RS_LSB = RD_LSB - REG_ADDR_W;
    localparam int RT_LSB = RS_LSB - REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    // Decoded instruction fields
    logic [3:0]            opcode;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;

    // Decoded instruction class
    logic is_writer;
    logic reads_rs;
    logic reads_rt;
    logic reads_rd;

    // Per-source hazard flags
    logic rs_hazard;
    logic rt_hazard;
    logic rd_hazard;

    // Scoreboard state
    logic                  ex_valid_q;
    logic [REG_ADDR_W-1:0] ex_rd_q;
    logic                  mem_valid_q;
    logic [REG_ADDR_W-1:0] mem_rd_q;

    // Value loaded into the EX slot at the next edge
    logic                  ex_valid_d;
    logic [REG_ADDR_W-1:0] ex_rd_d;

    // Split the instruction into its fields
    always_comb begin
        opcode = instr[OP_LSB +: 4];
        rd     = instr[RD_LSB +: REG_ADDR_W];
        rs     = instr[RS_LSB +: REG_ADDR_W];
        rt     = instr[RT_LSB +: REG_ADDR_W];
    end

    // Classify the opcode: which registers it reads and whether it writes rd
    always_comb begin
        is_writer = 1'b0;
        reads_rs  = 1'b0;
        reads_rt  = 1'b0;
        reads_rd  = 1'b0;
        unique case (opcode)
            OP_NOR, OP_AND, OP_OR: begin
                is_writer = 1'b1;
                reads_rs  = 1'b1;
                reads_rt  = 1'b1;
            end
            OP_ADDI: begin
                is_writer = 1'b1;
                reads_rs  = 1'b1;
            end
            OP_SW: begin
                reads_rs  = 1'b1;
                reads_rd  = 1'b1;
            end
            default: begin
                is_writer = 1'b0;
            end
        endcase
    end

    // A source hazards when it is read, is not R0, and a valid slot targets it
    always_comb begin
        rs_hazard = reads_rs && (rs != REG_ZERO) &&
                    ((ex_valid_q  && (ex_rd_q  == rs)) ||
                     (mem_valid_q && (mem_rd_q == rs)));
        rt_hazard = reads_rt && (rt != REG_ZERO) &&
                    ((ex_valid_q  && (ex_rd_q  == rt)) ||
                     (mem_valid_q && (mem_rd_q == rt)));
        rd_hazard = reads_rd && (rd != REG_ZERO) &&
                    ((ex_valid_q  && (ex_rd_q  == rd)) ||
                     (mem_valid_q && (mem_rd_q == rd)));
    end

    // Stall and hold enables; WB is not checked because the register file
    // writes in the first half-cycle and reads in the second
    always_comb begin
        ST            = instr_valid && (rs_hazard || rt_hazard || rd_hazard);
        pc_write_en   = ~ST;
        ifid_write_en = ~ST;
    end

    // Only an issuing writer with a nonzero rd is tracked; everything else is a bubble
    always_comb begin
        ex_valid_d = 1'b0;
        ex_rd_d    = REG_ZERO;
        if (instr_valid && !ST && is_writer && (rd != REG_ZERO)) begin
            ex_valid_d = 1'b1;
            ex_rd_d    = rd;
        end
    end

    // Scoreboard shift register: EX slot ages into the MEM slot every cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= REG_ZERO;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= REG_ZERO;
        end else begin
            mem_valid_q <= ex_valid_q;
            mem_rd_q    <= ex_rd_q;
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
        end
    end

    // Debug visibility of the scoreboard occupancy
    always_comb begin
        sb_ex_valid  = ex_valid_q;
        sb_mem_valid = mem_valid_q;
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Count stalled cycles, saturating at all-ones
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (ST && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    // Expose the counter
    always_comb begin
        stall_cnt = stall_cnt_q;
    end
`else
    // Counter not built
    always_comb begin
        stall_cnt = '0;
    end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed test of hazard_stall_unit. Each step clocks
// one edge then drives the ID instruction; a stalled instruction is re-applied
// to mimic the IF/ID hold. A second instance with CNT_W=2 shares the inputs to
// exercise counter saturation. Expected counts follow HAZARD_STALL_CNT_EN.
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;

    logic        st;
    logic        pc_we;
    logic        ifid_we;
    logic        ex_v;
    logic        mem_v;
    logic [15:0] cnt;

    logic        st_s;
    logic        pc_we_s;
    logic        ifid_we_s;
    logic        ex_v_s;
    logic        mem_v_s;
    logic [1:0]  cnt_s;

    int total_checks = 0;
    int pass_checks  = 0;

    hazard_stall_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .ST            (st),
        .pc_write_en   (pc_we),
        .ifid_write_en (ifid_we),
        .sb_ex_valid   (ex_v),
        .sb_mem_valid  (mem_v),
        .stall_cnt     (cnt)
    );

    hazard_stall_unit #(.CNT_W(2)) dut_small (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .ST            (st_s),
        .pc_write_en   (pc_we_s),
        .ifid_write_en (ifid_we_s),
        .sb_ex_valid   (ex_v_s),
        .sb_mem_valid  (mem_v_s),
        .stall_cnt     (cnt_s)
    );

    always #5 clk = ~clk;

    // Build an instruction word from its fields
    function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [3:0] rt);
        return {op, rd, rs, rt};
    endfunction

    // Expected counter value for the 16-bit instance after n stall edges
    function automatic logic [15:0] exp_cnt(input int n);
`ifdef HAZARD_STALL_CNT_EN
        return 16'(n);
`else
        return 16'd0;
`endif
    endfunction

    // Expected counter value for the 2-bit instance after n stall edges
    function automatic logic [15:0] exp_cnt_small(input int n);
`ifdef HAZARD_STALL_CNT_EN
        return (n > 3) ? 16'd3 : 16'(n);
`else
        return 16'd0;
`endif
    endfunction

    // Clock one edge, then present the next ID instruction
    task automatic apply_stimulus(input logic v, input logic [15:0] i);
        @(posedge clk);
        #1;
        instr_valid = v;
        instr       = i;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [15:0] obs,
                                input logic [15:0] exp);
        total_checks++;
        assert (obs === exp) begin
            pass_checks++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    localparam logic [3:0] SW = 4'h0, NOR = 4'h1, ADDI = 4'h3, AND = 4'h7, OR = 4'hF;

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0;

        // Reset held for two edges with ADDI r1,r0,5 in ID
        apply_stimulus(1'b1, enc(ADDI, 4'd1, 4'd0, 4'd5));
        apply_stimulus(1'b1, enc(ADDI, 4'd1, 4'd0, 4'd5));
        check_output("rst_st",      16'(st),    16'd0);
        check_output("rst_ex_v",    16'(ex_v),  16'd0);
        check_output("rst_mem_v",   16'(mem_v), 16'd0);
        check_output("rst_cnt",     cnt,        16'd0);
        check_output("rst_cnt_s",   16'(cnt_s), 16'd0);
        check_output("rst_pc_we",   16'(pc_we), 16'd1);
        check_output("rst_ifid_we", 16'(ifid_we), 16'd1);
        rst_n = 1'b1;

        // Back-to-back: ADDI r1 then OR r2,r1,r3 stalls two cycles
        apply_stimulus(1'b1, enc(OR, 4'd2, 4'd1, 4'd3));
        check_output("b2b_st1",     16'(st),    16'd1);
        check_output("b2b_pc_we1",  16'(pc_we), 16'd0);
        check_output("b2b_ifid1",   16'(ifid_we), 16'd0);
        check_output("b2b_ex_v1",   16'(ex_v),  16'd1);
        apply_stimulus(1'b1, enc(OR, 4'd2, 4'd1, 4'd3));
        check_output("b2b_st2",     16'(st),    16'd1);
        check_output("b2b_pc_we2",  16'(pc_we), 16'd0);
        check_output("b2b_ex_v2",   16'(ex_v),  16'd0);
        check_output("b2b_mem_v2",  16'(mem_v), 16'd1);
        apply_stimulus(1'b1, enc(OR, 4'd2, 4'd1, 4'd3));
        check_output("b2b_st3",     16'(st),    16'd0);
        check_output("b2b_pc_we3",  16'(pc_we), 16'd1);
        check_output("b2b_cnt",     cnt,        exp_cnt(2));

        // Distance two: ADDI r1; NOR r4,r5,r6; AND r2,r1,r1 stalls one cycle
        apply_stimulus(1'b1, enc(ADDI, 4'd1, 4'd0, 4'd1));
        check_output("d2_addi_st",  16'(st),    16'd0);
        apply_stimulus(1'b1, enc(NOR, 4'd4, 4'd5, 4'd6));
        check_output("d2_nor_st",   16'(st),    16'd0);
        apply_stimulus(1'b1, enc(AND, 4'd2, 4'd1, 4'd1));
        check_output("d2_and_st1",  16'(st),    16'd1);
        apply_stimulus(1'b1, enc(AND, 4'd2, 4'd1, 4'd1));
        check_output("d2_and_st2",  16'(st),    16'd0);
        check_output("d2_cnt",      cnt,        exp_cnt(3));

        // Distance three: ADDI r1, two independent, then a reader of r1
        apply_stimulus(1'b1, enc(ADDI, 4'd1, 4'd0, 4'd2));
        apply_stimulus(1'b1, enc(NOR, 4'd4, 4'd5, 4'd6));
        apply_stimulus(1'b1, enc(OR, 4'd7, 4'd5, 4'd6));
        check_output("d3_indep_st", 16'(st),    16'd0);
        apply_stimulus(1'b1, enc(AND, 4'd8, 4'd1, 4'd1));
        check_output("d3_st",       16'(st),    16'd0);

        // R0: ADDI r0 is not tracked and reads of r0 never stall
        apply_stimulus(1'b1, enc(ADDI, 4'd0, 4'd0, 4'd7));
        apply_stimulus(1'b1, enc(OR, 4'd2, 4'd0, 4'd0));
        check_output("r0_st",       16'(st),    16'd0);
        check_output("r0_ex_v",     16'(ex_v),  16'd0);

        // SW store data (rd field) depends on ADDI r3: two-cycle stall
        apply_stimulus(1'b1, enc(ADDI, 4'd3, 4'd0, 4'd1));
        apply_stimulus(1'b1, enc(SW, 4'd3, 4'd0, 4'd0));
        check_output("sw_st1",      16'(st),    16'd1);
        apply_stimulus(1'b1, enc(SW, 4'd3, 4'd0, 4'd0));
        check_output("sw_st2",      16'(st),    16'd1);
        apply_stimulus(1'b1, enc(SW, 4'd3, 4'd0, 4'd0));
        check_output("sw_st3",      16'(st),    16'd0);
        check_output("sw_cnt",      cnt,        exp_cnt(5));

        // SW does not write rd, so a following reader of r4 does not stall
        apply_stimulus(1'b1, enc(SW, 4'd4, 4'd0, 4'd0));
        apply_stimulus(1'b1, enc(AND, 4'd5, 4'd4, 4'd4));
        check_output("sw_nowr_st",  16'(st),    16'd0);
        check_output("sw_nowr_exv", 16'(ex_v),  16'd0);

        // instr_valid=0 suppresses ST and the bubble shortens the next stall
        apply_stimulus(1'b1, enc(ADDI, 4'd6, 4'd0, 4'd1));
        apply_stimulus(1'b0, enc(OR, 4'd9, 4'd6, 4'd6));
        check_output("bub_st",      16'(st),    16'd0);
        check_output("bub_pc_we",   16'(pc_we), 16'd1);
        apply_stimulus(1'b1, enc(OR, 4'd10, 4'd6, 4'd6));
        check_output("bub_st_next", 16'(st),    16'd1);
        check_output("bub_ex_v",    16'(ex_v),  16'd0);
        apply_stimulus(1'b1, enc(OR, 4'd10, 4'd6, 4'd6));
        check_output("bub_st_done", 16'(st),    16'd0);

        // Both slots match: stall persists until neither does
        apply_stimulus(1'b1, enc(ADDI, 4'd1, 4'd0, 4'd1));
        apply_stimulus(1'b1, enc(ADDI, 4'd2, 4'd0, 4'd1));
        apply_stimulus(1'b1, enc(OR, 4'd3, 4'd1, 4'd2));
        check_output("mm_st1",      16'(st),    16'd1);
        apply_stimulus(1'b1, enc(OR, 4'd3, 4'd1, 4'd2));
        check_output("mm_st2",      16'(st),    16'd1);
        apply_stimulus(1'b1, enc(OR, 4'd3, 4'd1, 4'd2));
        check_output("mm_st3",      16'(st),    16'd0);
        check_output("mm_cnt",      cnt,        exp_cnt(8));
        check_output("sat_cnt_s",   16'(cnt_s), exp_cnt_small(8));

        // Reset on the first stall cycle clears the scoreboard and counter
        apply_stimulus(1'b1, enc(ADDI, 4'd1, 4'd0, 4'd1));
        apply_stimulus(1'b1, enc(OR, 4'd2, 4'd1, 4'd1));
        check_output("mrst_st_pre", 16'(st),    16'd1);
        rst_n = 1'b0;
        apply_stimulus(1'b1, enc(OR, 4'd2, 4'd1, 4'd1));
        check_output("mrst_st",     16'(st),    16'd0);
        check_output("mrst_ex_v",   16'(ex_v),  16'd0);
        check_output("mrst_mem_v",  16'(mem_v), 16'd0);
        check_output("mrst_cnt",    cnt,        16'd0);
        check_output("mrst_cnt_s",  16'(cnt_s), 16'd0);
        rst_n = 1'b1;

        // After reset the counter restarts from zero
        apply_stimulus(1'b1, enc(OR, 4'd4, 4'd2, 4'd2));
        check_output("post_st1",    16'(st),    16'd1);
        apply_stimulus(1'b1, enc(OR, 4'd4, 4'd2, 4'd2));
        check_output("post_st2",    16'(st),    16'd1);
        apply_stimulus(1'b1, enc(OR, 4'd4, 4'd2, 4'd2));
        check_output("post_st3",    16'(st),    16'd0);
        check_output("post_cnt",    cnt,        exp_cnt(2));
        check_output("post_cnt_s",  16'(cnt_s), exp_cnt_small(2));

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Decode-stage RAW hazard detector for the 5-stage pipeline: IF, ID, EX, MEM, WB. The pipeline has no forwarding.
- Tracks the destination registers of instructions in flight in EX and MEM using a 2-entry scoreboard shift register.
- Generates the ST input of the control unit. Also generates the PC and IF/ID hold enables.
- Sits directly upstream of the control unit, beside the IF/ID register.

Parameters:
- INSTR_W, 16, instruction width; opcode [15:12], rd [11:8], rs [7:4], rt/imm [3:0]
- REG_ADDR_W, 4, register address width; 16 registers, R0 hardwired zero
- CNT_W, 16, width of the stall performance counter

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- instr_valid  input  1  IF/ID register holds a real instruction (0 = bubble)
- instr  input  INSTR_W  instruction currently in ID
- ST  output  1  stall; forces control-unit outputs to zero (bubble into EX)
- pc_write_en  output  1  PC update enable; equals ~ST
- ifid_write_en  output  1  IF/ID load enable; equals ~ST
- sb_ex_valid  output  1  scoreboard EX slot valid (visibility for debug and verification)
- sb_mem_valid  output  1  scoreboard MEM slot valid
- stall_cnt  output  CNT_W  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at a rising edge): both scoreboard slots invalid, rd fields 0, stall_cnt=0. ST therefore reads 0 in the following cycle, and pc_write_en=ifid_write_en=1.
- Register writers: NOR 0001, ADDI 0011, AND 0111, OR 1111 write rd. SW 0000 does not write. Any other opcode is a NOP.
- Source registers read by the ID instruction:
  - NOR, AND, OR: rs and rt.
  - ADDI: rs only.
  - SW: rs (base) and rd (store data).
  - Other opcodes: none.
- Match rule: a source matches a slot when the slot is valid, the slot rd equals the source, and the source is not R0.
- ST (combinational): instr_valid AND any source matches the EX slot or the MEM slot. WB needs no check, because the register file writes in the first half-cycle and reads in the second.
- Scoreboard update every edge when not in reset:
  - MEM slot <= EX slot.
  - EX slot <= {1, rd} when instr_valid, ~ST and the opcode is a writer with rd != 0.
  - Otherwise the EX slot is invalidated (bubble).
- Stall length:
  - Dependency on the immediately preceding writer: 2 cycles.
  - Dependency on the writer two instructions back: 1 cycle.
  - Dependency three or more instructions back: 0 cycles.
- While ST=1 the ID instruction is held unchanged (ifid_write_en=0) and re-evaluated each cycle. ST deasserts once the producer has left MEM.
- instr_valid=0: ST=0 and a bubble enters the EX slot.
- Multiple matches (EX and MEM both match): ST stays asserted until neither slot matches.
- Reset asserted mid-stall: the scoreboard clears at that edge, so ST=0 in the next cycle.
- stall_cnt: increments by 1 on each edge where ST=1. It saturates at all-ones and does not wrap.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined: the stall_cnt register exists and follows the counter rules above.
- Not defined: the counter is not instantiated and stall_cnt is tied to 0.
- ST, the scoreboard and both enables are identical in either build.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with instr=ADDI r1,r0,5 valid -> ST=0, sb_ex_valid=0, sb_mem_valid=0, stall_cnt=0.
- Back-to-back dependency: ADDI r1,r0,5 then OR r2,r1,r3 -> ST=1 for exactly 2 cycles on OR, pc_write_en=0 during those cycles, stall_cnt=2.
- Distance-2 dependency: ADDI r1; NOR r4,r5,r6; AND r2,r1,r1 -> ST=1 for exactly 1 cycle on AND. ADDI r1 followed by 2 independent instructions, then a reader of r1 -> ST=0.
- R0 and SW cases:
  - ADDI r0,r0,7 then OR r2,r0,r0 -> ST=0.
  - ADDI r3 then SW with rd=r3 -> ST=1 for 2 cycles.
  - SW rd=r4 then AND r5,r4,r4 -> ST=0.
- Reset mid-stall: assert rst_n=0 on the first stall cycle -> ST=0 next cycle and the scoreboard is empty.
- Counter saturation with CNT_W=2 and HAZARD_STALL_CNT_EN defined: 5 stall cycles -> stall_cnt=3. Without the macro -> stall_cnt=0 throughout.
